// File: rtl/reg_dump_writer.sv
// Walks x0..x31 then pc and writes each value as a 10-character unsigned decimal string.
// The string goes into the ASCII character buffer. Conversion is a bit-serial double-dabble.
module reg_dump_writer #(
  parameter int COLS          = 80,
  parameter int ROW_BASE      = 0,
  parameter int COL_BASE      = 0,
  parameter int ADDR_W        = 13,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [5:0]        reg_sel,
  input  logic [31:0]       reg_data,
  input  logic              ascii_ready,
  output logic              ascii_write_en,
  output logic [7:0]        ascii_input,
  output logic [ADDR_W-1:0] ascii_write_address,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD, CONV, WRITE, NEXT, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] bin, bin_n;
  logic [39:0] bcd, bcd_n, bcd_adj;
  logic [4:0]  cnt, cnt_n;
  logic [3:0]  col, col_n;
  logic [5:0]  sel_n;
  logic [31:0] addr_full;

  // Character for column c. A digit is blank when it and every digit to its left are zero.
  function automatic logic [7:0] digit_char(input logic [39:0] b, input logic [3:0] c);
    logic       lead;
    logic [3:0] d;
    lead = 1'b1;
    d    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i <= int'(c)) begin
        d = b[39-4*i -: 4];
        if (d != 4'd0) lead = 1'b0;
      end
    end
    if (BLANK_LEADING != 0 && lead && c != 4'd9) return 8'h20;
    return {4'h3, d};
  endfunction

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin;
    bcd_n   = bcd;
    cnt_n   = cnt;
    col_n   = col;
    sel_n   = reg_sel;
    case (state)
      IDLE: begin
        sel_n = 6'd0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        bin_n   = reg_data;
        bcd_n   = 40'd0;
        cnt_n   = 5'd0;
        state_n = CONV;
      end
      CONV: begin
        {bcd_n, bin_n} = {bcd_adj, bin} << 1;
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) begin
          state_n = WRITE;
          col_n   = 4'd0;
        end
      end
      WRITE: begin
        if (ascii_ready) begin
          if (col == 4'd9) state_n = NEXT;
          else             col_n   = col + 4'd1;
        end
      end
      NEXT: begin
        if (reg_sel == 6'd32) begin
          state_n = DONE;
        end else begin
          sel_n   = reg_sel + 6'd1;
          state_n = LOAD;
        end
      end
      DONE: begin
        sel_n   = 6'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    addr_full = 32'((ROW_BASE + int'(sel_n)) * COLS + COL_BASE + int'(col_n));
  end

  // Outputs are loaded from next-state values so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      bin                 <= 32'd0;
      bcd                 <= 40'd0;
      cnt                 <= 5'd0;
      col                 <= 4'd0;
      reg_sel             <= 6'd0;
      ascii_write_en      <= 1'b0;
      ascii_input         <= 8'h00;
      ascii_write_address <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      state          <= state_n;
      bin            <= bin_n;
      bcd            <= bcd_n;
      cnt            <= cnt_n;
      col            <= col_n;
      reg_sel        <= sel_n;
      ascii_write_en <= (state_n == WRITE);
      busy           <= (state_n != IDLE);
      done           <= (state_n == DONE);
      if (state_n == WRITE) begin
        ascii_input         <= digit_char(bcd_n, col_n);
        ascii_write_address <= addr_full[ADDR_W-1:0];
      end
    end
  end

endmodule
